// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write sequencer.
package regfile_pkg;

    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 32;
    localparam int unsigned NREGS = 1 << AW;

    typedef enum logic {INIT, RUN} wr_state_t;

endpackage

// File: rtl/regfile_wr_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping modulo NREQ; one-hot grant plus encoded index.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int unsigned   cand;
    logic [IW-1:0] cand_idx;

    always_comb begin
        gnt      = '0;
        idx      = '0;
        any      = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            cand_idx = IW'(cand);
            if (!any && req[cand_idx]) begin
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
                any           = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Write-port sequencer: clears every register after reset, then round-robin
// arbitrates NREQ valid/ready requesters onto registered rf_we/rf_wa/rf_wd.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned AW   = regfile_pkg::AW,
    parameter int unsigned DW   = regfile_pkg::DW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_wa,
    output logic [DW-1:0]        rf_wd,
    output logic                 init_done
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wr_state_t     state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_wa_q, rf_wa_d;
    logic [DW-1:0] rf_wd_q, rf_wd_d;
    logic          init_done_q, init_done_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IW-1:0]   arb_idx;
    logic            arb_any;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= INIT;
            clr_cnt_q   <= '0;
            rr_ptr_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_wa_q     <= '0;
            rf_wd_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_wa_q     <= rf_wa_d;
            rf_wd_q     <= rf_wd_d;
            init_done_q <= init_done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == INIT && clr_cnt_q == '1) begin
            state_d = RUN;
        end
    end

    // Registered write port; an idle RUN cycle only drops the enable.
    always_comb begin
        clr_cnt_d   = clr_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        rf_we_d     = 1'b0;
        rf_wa_d     = rf_wa_q;
        rf_wd_d     = rf_wd_q;
        init_done_d = init_done_q;
        case (state_q)
            INIT: begin
                rf_we_d   = 1'b1;
                rf_wa_d   = clr_cnt_q;
                rf_wd_d   = '0;
                clr_cnt_d = clr_cnt_q + AW'(1);
                if (clr_cnt_q == '1) begin
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (arb_any) begin
                    rf_we_d  = 1'b1;
                    rf_wa_d  = req_addr[arb_idx*AW +: AW];
                    rf_wd_d  = req_data[arb_idx*DW +: DW];
                    rr_ptr_d = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (state_q == RUN) begin
            req_ready = arb_gnt;
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_wa     = rf_wa_q;
    assign rf_wd     = rf_wd_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Self-checking bench for regfile_wr_arbiter: directed scenarios plus
// randomized requesters compared every cycle against a behavioural model.
module tb_regfile_wr_arbiter;

    localparam int NREQ  = 2;
    localparam int AW    = 6;
    localparam int DW    = 32;
    localparam int NREGS = 1 << AW;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 rf_we;
    logic [AW-1:0]        rf_wa;
    logic [DW-1:0]        rf_wd;
    logic                 init_done;

    int tests = 0;
    int fails = 0;

    regfile_wr_arbiter #(
        .NREQ (NREQ),
        .AW   (AW),
        .DW   (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Behavioural model: sweep counter, then round-robin by scanning from ptr.
    int          m_cnt;
    bit          m_run;
    int          m_ptr;
    bit          m_we;
    int          m_wa;
    logic [DW-1:0] m_wd;
    bit          m_done;
    int          m_last;

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        int g;
        if (reset) begin
            m_cnt = 0; m_run = 0; m_ptr = 0; m_we = 0; m_wa = 0; m_wd = '0;
            m_done = 0; m_last = -1;
        end else if (!m_run) begin
            m_we = 1; m_wa = m_cnt; m_wd = '0; m_last = -1;
            m_cnt++;
            if (m_cnt == NREGS) begin
                m_run = 1; m_done = 1;
            end
        end else begin
            g = pick(req_valid, m_ptr);
            m_last = g;
            if (g >= 0) begin
                m_we  = 1;
                m_wa  = int'(req_addr[g*AW +: AW]);
                m_wd  = req_data[g*DW +: DW];
                m_ptr = (g + 1) % NREQ;
            end else begin
                m_we = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] er;
        int g;
        er = '0;
        g  = pick(req_valid, m_ptr);
        if (m_run && g >= 0) er[g] = 1'b1;
        check("m_rf_we", rf_we, m_we);
        check("m_rf_wa", rf_wa, m_wa);
        check("m_rf_wd", rf_wd, m_wd);
        check("m_init_done", init_done, m_done);
        check("m_req_ready", req_ready, er);
    end

    task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic edge_plus1();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_we"}, rf_we, 0);
        check({tag, "_wa"}, rf_wa, 0);
        check({tag, "_wd"}, rf_wd, 0);
        check({tag, "_done"}, init_done, 0);
        check({tag, "_ready"}, req_ready, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] ca [NREQ];
        logic [DW-1:0] cd [NREQ];
        int g;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;

        repeat (2) @(posedge clk);
        #1 check_zero("rst");

        // Release reset; requester 1 waits through the sweep.
        #1 reset = 1'b0;
        set_req(1, 1'b1, 6'd63, 32'h1);
        for (int i = 0; i < NREGS; i++) begin
            edge_plus1();
            check("sweep_we", rf_we, 1);
            check("sweep_wa", rf_wa, i);
            check("sweep_wd", rf_wd, 0);
            check("sweep_done", init_done, (i == NREGS - 1) ? 1 : 0);
            check("sweep_ready", req_ready, (i == NREGS - 1) ? 2'b10 : 2'b00);
        end
        edge_plus1();
        check("early_we", rf_we, 1);
        check("early_wa", rf_wa, 63);
        check("early_wd", rf_wd, 32'h1);
        #1 set_req(1, 1'b0, '0, '0);
        edge_plus1();
        check("early_idle_we", rf_we, 0);

        #1 set_req(0, 1'b1, 6'd5, 32'hDEADBEEF);
        #1 check("r0_ready", req_ready, 2'b01);
        edge_plus1();
        check("r0_we", rf_we, 1);
        check("r0_wa", rf_wa, 5);
        check("r0_wd", rf_wd, 32'hDEADBEEF);
        #1 set_req(0, 1'b0, '0, '0);
        edge_plus1();
        check("r0_idle_we", rf_we, 0);

        repeat (10) begin
            edge_plus1();
            check("idle_we", rf_we, 0);
            check("idle_ready", req_ready, 0);
        end

        // Pointer was left at 1, so requester 1 wins first, then alternation.
        ca[0] = 6'd10; cd[0] = 32'hA0;
        ca[1] = 6'd11; cd[1] = 32'hB0;
        #1 set_req(0, 1'b1, ca[0], cd[0]);
        set_req(1, 1'b1, ca[1], cd[1]);
        #1 check("alt_first_ready", req_ready, 2'b10);
        for (int k = 0; k < 8; k++) begin
            g = (k + 1) % 2;
            edge_plus1();
            check("alt_we", rf_we, 1);
            check("alt_wa", rf_wa, ca[g]);
            check("alt_wd", rf_wd, cd[g]);
            ca[g] = ca[g] + 6'd2;
            cd[g] = cd[g] + 32'h100;
            #1;
            if (k < 7) begin
                set_req(g, 1'b1, ca[g], cd[g]);
                #1 check("alt_ready", req_ready, (g == 0) ? 2'b10 : 2'b01);
            end
        end

        // Reset with requester 0 pending and a write just registered.
        set_req(1, 1'b0, '0, '0);
        set_req(0, 1'b1, 6'd7, 32'h77);
        #1 reset = 1'b1;
        #1 check_zero("async_rst");
        edge_plus1();
        #1 reset = 1'b0;
        set_req(0, 1'b0, '0, '0);
        for (int i = 0; i < NREGS; i++) begin
            edge_plus1();
            check("resweep_wa", rf_wa, i);
        end
        #1 set_req(0, 1'b1, 6'd20, 32'hC0);
        set_req(1, 1'b1, 6'd21, 32'hC1);
        #1 check("ptr_reset_ready", req_ready, 2'b01);
        edge_plus1();
        check("ptr_reset_wa", rf_wa, 20);
        #1 set_req(0, 1'b0, '0, '0);
        set_req(1, 1'b0, '0, '0);

        // Randomized requesters holding requests until granted.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #2;
            if (c == 1500) reset = 1'b1;
            if (c == 1502) reset = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || m_last == i) begin
                    set_req(i, ($urandom_range(0, 2) != 0), AW'($urandom), $urandom);
                end
            end
        end
        req_valid = '0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
